// File: rtl/mbtrain_pkg.sv
// Shared MBTRAIN definitions: sequencer state encodings and sideband message codes
// used by the sequencer and the per-substate training FSMs.
package mbtrain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_RUN    = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } seq_state_e;

    localparam logic [3:0] SB_NONE       = 4'b0000;
    localparam logic [3:0] SB_START_REQ  = 4'b0001;
    localparam logic [3:0] SB_START_RESP = 4'b0010;
    localparam logic [3:0] SB_END_REQ    = 4'b0011;
    localparam logic [3:0] SB_END_RESP   = 4'b0100;

endpackage

// File: rtl/mbtrain_timeout_counter.sv
// Saturating timeout counter with synchronous clear; o_expired flags the final
// count (TIMEOUT_CYCLES-1). Shared by the sequencer and substate FSMs.
module mbtrain_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != LP_LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LP_LAST);

endmodule

// File: rtl/mbtrain_substate_sequencer.sv
// MBTRAIN top-level controller: enables the substate FSMs one at a time in index
// order, muxes the active one onto the shared sideband TX path, and guards each with a timeout.
module mbtrain_substate_sequencer
    import mbtrain_pkg::*;
#(
    parameter int unsigned N_SUB          = 4,
    parameter int unsigned IDX_W          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic [N_SUB-1:0]     i_skip_mask,
    input  logic [N_SUB-1:0]     i_sub_test_ack,
    input  logic [4*N_SUB-1:0]   i_sub_sideband_message,
    input  logic [N_SUB-1:0]     i_sub_valid_tx,
    output logic [N_SUB-1:0]     o_sub_en,
    output logic [3:0]           o_sideband_message,
    output logic                 o_valid_tx,
    output logic [IDX_W-1:0]     o_active_idx,
    output logic                 o_done,
    output logic                 o_timeout_err
);

    localparam logic [IDX_W-1:0] LP_LAST_IDX = IDX_W'(N_SUB - 1);

    seq_state_e       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [N_SUB-1:0] r_mask;
    logic [N_SUB-1:0] r_sub_en;
    logic             r_done;
    logic             r_err;

    logic             w_expired;
    logic [3:0]       w_msg;
    logic             w_valid;

    mbtrain_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (r_state != ST_RUN),
        .i_en      (r_state == ST_RUN),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_mask   <= '0;
            r_sub_en <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else if (!i_en) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_sub_en <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_SELECT;
                    r_mask  <= i_skip_mask;
                    r_idx   <= '0;
                end
                ST_SELECT: begin
                    if (r_mask[r_idx]) begin
                        if (r_idx == LP_LAST_IDX) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_state         <= ST_RUN;
                        r_sub_en        <= '0;
                        r_sub_en[r_idx] <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Ack has priority over a timeout expiring in the same cycle.
                    if (i_sub_test_ack[r_idx]) begin
                        r_state  <= ST_GAP;
                        r_sub_en <= '0;
                    end else if (w_expired) begin
                        r_state  <= ST_ERROR;
                        r_sub_en <= '0;
                        r_err    <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_idx == LP_LAST_IDX) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= ST_SELECT;
                    end
                end
                ST_DONE:  r_state <= ST_DONE;
                ST_ERROR: r_state <= ST_ERROR;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_msg   = SB_NONE;
        w_valid = 1'b0;
        if (r_state == ST_RUN) begin
            w_msg   = i_sub_sideband_message[{r_idx, 2'b00} +: 4];
            w_valid = i_sub_valid_tx[r_idx];
        end
    end

    assign o_sub_en           = r_sub_en;
    assign o_sideband_message = w_msg;
    assign o_valid_tx         = w_valid;
    assign o_active_idx       = r_idx;
    assign o_done             = r_done;
    assign o_timeout_err      = r_err;

endmodule
